// File: rtl/vga_frame_buffer.sv
// Double-buffered 16x8 frame store. The producer writes the back bank and Commit
// swaps the banks at the next VSync edge. The new display image is then copied into the back bank.
module vga_frame_buffer #(
  parameter logic VSYNC_ACT = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WrEn,
  input  logic [3:0] WrAddr,
  input  logic [7:0] WrData,
  input  logic       Commit,
  input  logic       VSync,
  input  logic [3:0] RdAddr,
  output logic [7:0] RdData,
  output logic       Ack,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       disp_sel_q, disp_sel_d;
  logic       ack_q, ack_d;
  logic       vs_prev_q;
  logic [7:0] rd_data_q;
  logic [7:0] mem_q [2][16];

  logic       vs_edge;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  assign vs_edge = (vs_prev_q == ~VSYNC_ACT) && (VSync == VSYNC_ACT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    disp_sel_d = disp_sel_q;
    ack_d      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = WrAddr;
    wr_data    = WrData;
    case (state_q)
      IDLE: begin
        if (WrEn) begin
          wr_en = 1'b1;
          ack_d = 1'b1;
        end
        if (Commit) state_d = PENDING;
      end
      PENDING: begin
        if (vs_edge) begin
          disp_sel_d = ~disp_sel_q;
          cnt_d      = 4'd0;
          state_d    = COPY;
        end
      end
      COPY: begin
        // disp_sel_q already points at the new display bank, so the back bank is refreshed from it
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = mem_q[disp_sel_q][cnt_q];
        cnt_d   = 4'(cnt_q + 4'd1);
        if (cnt_q == 4'd15) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      disp_sel_q <= 1'b0;
      ack_q      <= 1'b0;
      vs_prev_q  <= ~VSYNC_ACT;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      disp_sel_q <= disp_sel_d;
      ack_q      <= ack_d;
      vs_prev_q  <= VSync;
      // Read through the post-edge selection so a read at the swap edge sees the new image
      rd_data_q  <= mem_q[disp_sel_d][RdAddr];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 16; i++) begin
          mem_q[b][i] <= 8'h00;
        end
      end
    end else if (wr_en) begin
      mem_q[~disp_sel_q][wr_addr] <= wr_data;
    end
  end

  assign RdData = rd_data_q;
  assign Ack    = ack_q;
  assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Bench for vga_frame_buffer: directed scenarios plus random traffic, all checked
// against an image-level model of the published and draft frames.
module tb_vga_frame_buffer;

  localparam logic ACT = 1'b0;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       WrEn = 1'b0;
  logic [3:0] WrAddr = 4'd0;
  logic [7:0] WrData = 8'h00;
  logic       Commit = 1'b0;
  logic       VSync = ~ACT;
  logic [3:0] RdAddr = 4'd0;
  logic [7:0] RdData;
  logic       Ack;
  logic       Busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: what the display shows, what the producer has drafted, and how busy we are
  logic [7:0] m_disp  [16];
  logic [7:0] m_draft [16];
  bit         m_pending = 1'b0;
  int         m_copy_left = 0;
  logic       m_prev_vs = ~ACT;
  logic [7:0] e_rd;
  logic       e_ack;
  logic       e_busy;
  logic       vs_lvl = ~ACT;

  vga_frame_buffer #(.VSYNC_ACT(ACT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .WrEn  (WrEn),
    .WrAddr(WrAddr),
    .WrData(WrData),
    .Commit(Commit),
    .VSync (VSync),
    .RdAddr(RdAddr),
    .RdData(RdData),
    .Ack   (Ack),
    .Busy  (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic we, input logic [3:0] wa,
                      input logic [7:0] wd, input logic cm, input logic vs,
                      input logic [3:0] ra);
    logic edge_v;
    RESET = rst_n; WrEn = we; WrAddr = wa; WrData = wd;
    Commit = cm; VSync = vs; RdAddr = ra;
    edge_v = (m_prev_vs == ~ACT) && (vs == ACT);
    e_ack = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_disp[i]  = 8'h00;
        m_draft[i] = 8'h00;
      end
      m_pending   = 1'b0;
      m_copy_left = 0;
      m_prev_vs   = ~ACT;
    end else begin
      if (m_copy_left > 0) begin
        m_copy_left--;
      end else if (m_pending) begin
        if (edge_v) begin
          m_disp      = m_draft;
          m_pending   = 1'b0;
          m_copy_left = 16;
        end
      end else begin
        if (we) begin
          m_draft[wa] = wd;
          e_ack = 1'b1;
        end
        if (cm) m_pending = 1'b1;
      end
      m_prev_vs = vs;
    end
    e_rd   = m_disp[ra];
    e_busy = m_pending || (m_copy_left > 0);
    @(posedge CLK);
    #1;
    check("RdData", RdData, e_rd);
    check("Ack", {7'd0, Ack}, {7'd0, e_ack});
    check("Busy", {7'd0, Busy}, {7'd0, e_busy});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, vs_lvl, 4'($urandom_range(0, 15)));
  endtask

  task automatic vs_pulse();
    vs_lvl = ACT;
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, vs_lvl, 4'd3);
    vs_lvl = ~ACT;
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, vs_lvl, 4'd3);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, vs_lvl, 4'(i));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_disp[i]  = 8'h00;
      m_draft[i] = 8'h00;
    end

    // Reset, then every address reads zero
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, vs_lvl, 4'd0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, vs_lvl, 4'd0);
    read_all();

    // Write addr3, commit, swap on a VSync pulse, let the copy finish
    step(1'b1, 1'b1, 4'd3, 8'h5A, 1'b0, vs_lvl, 4'd3);
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, vs_lvl, 4'd3);
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, vs_lvl, 4'd3);
    idle(2);
    vs_pulse();
    idle(18);
    read_all();

    // Write with Commit together, then a refused write while pending
    step(1'b1, 1'b1, 4'd5, 8'h77, 1'b1, vs_lvl, 4'd5);
    step(1'b1, 1'b1, 4'd6, 8'hEE, 1'b0, vs_lvl, 4'd6);
    step(1'b1, 1'b1, 4'd6, 8'hEE, 1'b1, vs_lvl, 4'd6);
    vs_pulse();
    step(1'b1, 1'b1, 4'd9, 8'h99, 1'b1, vs_lvl, 4'd9);
    idle(17);
    read_all();

    // Only addr7 changes; earlier contents survive via the copy-back
    step(1'b1, 1'b1, 4'd7, 8'h11, 1'b0, vs_lvl, 4'd7);
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, vs_lvl, 4'd7);
    vs_pulse();
    idle(17);
    read_all();

    // Commit coinciding with a VSync edge must wait one more frame
    step(1'b1, 1'b1, 4'd2, 8'hC3, 1'b0, vs_lvl, 4'd2);
    vs_lvl = ACT;
    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, vs_lvl, 4'd2);
    idle(3);
    vs_lvl = ~ACT;
    idle(2);
    vs_pulse();
    idle(17);
    read_all();

    // Random traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0) vs_lvl = ~vs_lvl;
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 11) == 0), vs_lvl, 4'($urandom_range(0, 15)));
    end
    vs_lvl = ~ACT;
    idle(40);
    read_all();

    // Reset in the middle of a copy
    step(1'b1, 1'b1, 4'd4, 8'hA4, 1'b1, vs_lvl, 4'd4);
    vs_pulse();
    idle(7);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, vs_lvl, 4'd4);
    read_all();
    step(1'b1, 1'b1, 4'd1, 8'h3C, 1'b0, vs_lvl, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
